// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: phase encoding and
// seven-segment patterns (active-low, bit order {g,f,e,d,c,b,a}).
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_WALK   = 2'd3
    } state_e;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] seg_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle timing tick every
// TICK_DIV cycles (every cycle when TICK_DIV is 1).
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == TERM);

    // Wrap on the terminal count, otherwise count up.
    always_comb begin
        if (tick) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// N-approach round-robin traffic-light controller with min green, yellow and
// all-red clearance. Define PED_REQ_EN to add the pedestrian WALK phase.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int N_DIR     = 2,
    parameter int TICK_DIV  = 50_000_000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
`ifdef PED_REQ_EN
    ,
    parameter int WALK_T    = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_DIR-1:0] car,
    output logic [N_DIR-1:0] green,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] red,
    output logic [6:0]       seg0
`ifdef PED_REQ_EN
    ,
    input  logic             ped_req,
    output logic             walk
`endif
);

    localparam int AW  = $clog2(N_DIR);
    localparam int AW1 = AW + 1;
`ifdef PED_REQ_EN
    localparam int PHASE_MAX0 = (GREEN_MAX > WALK_T) ? GREEN_MAX : WALK_T;
`else
    localparam int PHASE_MAX0 = GREEN_MAX;
`endif
    localparam int PHASE_MAX1 = (PHASE_MAX0 > YELLOW_T) ? PHASE_MAX0 : YELLOW_T;
    localparam int PHASE_MAX  = (PHASE_MAX1 > ALLRED_T) ? PHASE_MAX1 : ALLRED_T;
    localparam int EW         = $clog2(PHASE_MAX);

    localparam logic [EW-1:0]    E_ZERO    = {EW{1'b0}};
    localparam logic [EW-1:0]    E_ONE     = EW'(1);
    localparam logic [EW-1:0]    E_GMIN    = EW'(GREEN_MIN - 1);
    localparam logic [EW-1:0]    E_GSAT    = EW'(GREEN_MAX - 1);
    localparam logic [EW-1:0]    E_YELLOW  = EW'(YELLOW_T - 1);
    localparam logic [EW-1:0]    E_ALLRED  = EW'(ALLRED_T - 1);
`ifdef PED_REQ_EN
    localparam logic [EW-1:0]    E_WALK    = EW'(WALK_T - 1);
`endif
    localparam logic [AW1-1:0]   NDIR_W    = AW1'(N_DIR);
    localparam logic [N_DIR-1:0] LAMP0     = {{(N_DIR-1){1'b0}}, 1'b1};

    // First pending approach after 'from', wrapping; MSB flags a hit.
    function automatic logic [AW:0] rr_pick(input logic [N_DIR-1:0] pend,
                                            input logic [AW-1:0]    from);
        logic [AW:0]    pick;
        logic [AW1-1:0] sum;
        pick = {AW1{1'b0}};
        for (int k = N_DIR - 1; k >= 1; k--) begin
            sum  = {1'b0, from} + AW1'(k);
            sum  = (sum >= NDIR_W) ? (sum - NDIR_W) : sum;
            pick = pend[sum[AW-1:0]] ? {1'b1, sum[AW-1:0]} : pick;
        end
        return pick;
    endfunction

    state_e           state_q,   state_d;
    logic [AW-1:0]    active_q,  active_d;
    logic [EW-1:0]    elapsed_q, elapsed_d;
    logic [N_DIR-1:0] req_q,     req_d;
    logic [N_DIR-1:0] req_eff_s;
    logic [AW:0]      pick_s;
    logic             enter_green_s;
    logic             tick_s;

    logic [N_DIR-1:0] lamp_s;
    logic [N_DIR-1:0] green_q,  green_d;
    logic [N_DIR-1:0] yellow_q, yellow_d;
    logic [N_DIR-1:0] red_q,    red_d;
    logic [6:0]       seg_q,    seg_d;
`ifdef PED_REQ_EN
    logic             ped_pend_q, ped_pend_d;
    logic             ped_eff_s;
    logic             walk_q,     walk_d;
`endif

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Phase sequencing, request latching and round-robin hand-over.
    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        elapsed_d     = elapsed_q;
        req_eff_s     = req_q | car;
        req_d         = req_eff_s;
        pick_s        = rr_pick(req_eff_s, active_q);
        enter_green_s = 1'b0;
`ifdef PED_REQ_EN
        ped_eff_s     = ped_pend_q | ped_req;
        ped_pend_d    = ped_eff_s;
`endif
        if (tick_s) begin
            case (state_q)
                ST_GREEN: begin
                    if ((elapsed_q >= E_GMIN) && pick_s[AW]) begin
                        state_d   = ST_YELLOW;
                        elapsed_d = E_ZERO;
                    end else if (elapsed_q < E_GSAT) begin
                        elapsed_d = elapsed_q + E_ONE;
                    end else begin
                        elapsed_d = elapsed_q;
                    end
                end
                ST_YELLOW: begin
                    if (elapsed_q == E_YELLOW) begin
                        state_d   = ST_ALLRED;
                        elapsed_d = E_ZERO;
                    end else begin
                        elapsed_d = elapsed_q + E_ONE;
                    end
                end
                ST_ALLRED: begin
                    if (elapsed_q == E_ALLRED) begin
`ifdef PED_REQ_EN
                        if (ped_eff_s) begin
                            state_d    = ST_WALK;
                            elapsed_d  = E_ZERO;
                            ped_pend_d = 1'b0;
                        end else begin
                            enter_green_s = 1'b1;
                        end
`else
                        enter_green_s = 1'b1;
`endif
                    end else begin
                        elapsed_d = elapsed_q + E_ONE;
                    end
                end
`ifdef PED_REQ_EN
                ST_WALK: begin
                    if (elapsed_q == E_WALK) begin
                        enter_green_s = 1'b1;
                    end else begin
                        elapsed_d = elapsed_q + E_ONE;
                    end
                end
`endif
                default: begin
                    state_d   = ST_GREEN;
                    elapsed_d = E_ZERO;
                end
            endcase
            // The approach being given green loses its request even if its sensor is active.
            if (enter_green_s) begin
                state_d   = ST_GREEN;
                elapsed_d = E_ZERO;
                active_d  = pick_s[AW] ? pick_s[AW-1:0] : active_q;
                req_d[active_d] = 1'b0;
            end else begin
                req_d = req_d;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_GREEN;
            active_q  <= {AW{1'b0}};
            elapsed_q <= E_ZERO;
            req_q     <= {N_DIR{1'b0}};
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            elapsed_q <= elapsed_d;
            req_q     <= req_d;
        end
    end

`ifdef PED_REQ_EN
    // Pedestrian request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end
`endif

    // Lamp and display decode from the current phase.
    always_comb begin
        lamp_s   = LAMP0 << active_q;
        green_d  = {N_DIR{1'b0}};
        yellow_d = {N_DIR{1'b0}};
        red_d    = {N_DIR{1'b1}};
        seg_d    = SEG_DASH;
`ifdef PED_REQ_EN
        walk_d   = 1'b0;
`endif
        case (state_q)
            ST_GREEN: begin
                green_d = lamp_s;
                red_d   = ~lamp_s;
                seg_d   = seg_digit(4'(active_q));
            end
            ST_YELLOW: begin
                yellow_d = lamp_s;
                red_d    = ~lamp_s;
                seg_d    = seg_digit(4'(active_q));
            end
            ST_ALLRED: begin
                seg_d = SEG_DASH;
            end
`ifdef PED_REQ_EN
            ST_WALK: begin
                walk_d = 1'b1;
            end
`endif
            default: begin
                seg_d = SEG_DASH;
            end
        endcase
    end

    // Output registers; reset shows approach 0 green straight away.
    always_ff @(posedge clk) begin
        if (reset) begin
            green_q  <= LAMP0;
            yellow_q <= {N_DIR{1'b0}};
            red_q    <= ~LAMP0;
            seg_q    <= SEG_0;
`ifdef PED_REQ_EN
            walk_q   <= 1'b0;
`endif
        end else begin
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
            seg_q    <= seg_d;
`ifdef PED_REQ_EN
            walk_q   <= walk_d;
`endif
        end
    end

    assign green  = green_q;
    assign yellow = yellow_q;
    assign red    = red_q;
    assign seg0   = seg_q;
`ifdef PED_REQ_EN
    assign walk   = walk_q;
`endif

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Randomised bench: two controller configurations driven with the same car
// stream, each compared every cycle against a phase/timer reference model.
module tb_traffic_intersection_ctrl;

    localparam int A_N = 3, A_DIV = 1, A_GMIN = 2, A_GMAX = 20, A_YT = 2, A_ART = 1;
    localparam int B_N = 4, B_DIV = 3, B_GMIN = 3, B_GMAX = 4,  B_YT = 2, B_ART = 2;
    localparam int PH_G = 0, PH_Y = 1, PH_R = 2;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] SEG_DASH = 7'h3F;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] car_v = 4'd0;

    logic [2:0] a_green, a_yellow, a_red;
    logic [6:0] a_seg;
    logic [3:0] b_green, b_yellow, b_red;
    logic [6:0] b_seg;
`ifdef PED_REQ_EN
    logic       a_walk, b_walk;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int         m_phase [2];
    int         m_active[2];
    int         m_cnt   [2];
    int         m_pcnt  [2];
    logic [3:0] m_req   [2];
    logic [3:0] e_green [2];
    logic [3:0] e_yellow[2];
    logic [3:0] e_red   [2];
    logic [6:0] e_seg   [2];

    logic [2:0] order_q[$];

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .N_DIR(A_N), .TICK_DIV(A_DIV), .GREEN_MIN(A_GMIN), .GREEN_MAX(A_GMAX),
        .YELLOW_T(A_YT), .ALLRED_T(A_ART)
    ) u_dut_a (
        .clk(clk), .reset(rst), .car(car_v[2:0]),
        .green(a_green), .yellow(a_yellow), .red(a_red), .seg0(a_seg)
`ifdef PED_REQ_EN
        , .ped_req(1'b0), .walk(a_walk)
`endif
    );

    traffic_intersection_ctrl #(
        .N_DIR(B_N), .TICK_DIV(B_DIV), .GREEN_MIN(B_GMIN), .GREEN_MAX(B_GMAX),
        .YELLOW_T(B_YT), .ALLRED_T(B_ART)
    ) u_dut_b (
        .clk(clk), .reset(rst), .car(car_v),
        .green(b_green), .yellow(b_yellow), .red(b_red), .seg0(b_seg)
`ifdef PED_REQ_EN
        , .ped_req(1'b0), .walk(b_walk)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advances model k across one clock edge; expected outputs are the lamps
    // of the phase held before the edge (outputs are registered).
    task automatic model_step(input int k, input int n, input int div, input int gmin,
                              input int yt, input int art, input logic [3:0] carv,
                              input logic r);
        logic [3:0] mask, pend;
        bit         tick;
        int         nxt;
        mask = 4'((1 << n) - 1);
        if (r) begin
            m_phase[k] = PH_G; m_active[k] = 0; m_cnt[k] = 0; m_pcnt[k] = 0;
            m_req[k]   = 4'd0;
            e_green[k] = 4'd1; e_yellow[k] = 4'd0; e_red[k] = mask & 4'b1110;
            e_seg[k]   = SEG_TAB[0];
            return;
        end
        e_green[k] = 4'd0; e_yellow[k] = 4'd0; e_red[k] = mask; e_seg[k] = SEG_DASH;
        if (m_phase[k] == PH_G) begin
            e_green[k] = 4'(1 << m_active[k]);
            e_red[k]   = mask & ~e_green[k];
            e_seg[k]   = SEG_TAB[m_active[k]];
        end else if (m_phase[k] == PH_Y) begin
            e_yellow[k] = 4'(1 << m_active[k]);
            e_red[k]    = mask & ~e_yellow[k];
            e_seg[k]    = SEG_TAB[m_active[k]];
        end
        pend = (m_req[k] | carv) & mask;
        tick = (m_pcnt[k] == div - 1);
        m_pcnt[k] = tick ? 0 : m_pcnt[k] + 1;
        nxt = m_active[k];
        for (int d = n - 1; d >= 1; d--) begin
            if (pend[(m_active[k] + d) % n]) nxt = (m_active[k] + d) % n;
        end
        m_req[k] = pend;
        if (tick) begin
            m_cnt[k]++;
            case (m_phase[k])
                PH_G: if (m_cnt[k] >= gmin && nxt != m_active[k]) begin
                    m_phase[k] = PH_Y; m_cnt[k] = 0;
                end
                PH_Y: if (m_cnt[k] == yt) begin
                    m_phase[k] = PH_R; m_cnt[k] = 0;
                end
                default: if (m_cnt[k] == art) begin
                    m_phase[k] = PH_G; m_cnt[k] = 0; m_active[k] = nxt;
                    m_req[k][nxt] = 1'b0;
                end
            endcase
        end
    endtask

    task automatic cycle(input logic [3:0] c, input logic r);
        car_v = c;
        rst   = r;
        model_step(0, A_N, A_DIV, A_GMIN, A_YT, A_ART, c, r);
        model_step(1, B_N, B_DIV, B_GMIN, B_YT, B_ART, c, r);
        @(negedge clk);
        check_eq("A.green",  32'(a_green),  32'(e_green[0]));
        check_eq("A.yellow", 32'(a_yellow), 32'(e_yellow[0]));
        check_eq("A.red",    32'(a_red),    32'(e_red[0]));
        check_eq("A.seg0",   32'(a_seg),    32'(e_seg[0]));
        check_eq("B.green",  32'(b_green),  32'(e_green[1]));
        check_eq("B.yellow", 32'(b_yellow), 32'(e_yellow[1]));
        check_eq("B.red",    32'(b_red),    32'(e_red[1]));
        check_eq("B.seg0",   32'(b_seg),    32'(e_seg[1]));
`ifdef PED_REQ_EN
        check_eq("A.walk", 32'(a_walk), 32'd0);
        check_eq("B.walk", 32'(b_walk), 32'd0);
`endif
    endtask

    initial begin
        logic [3:0] c;
        logic       r;

        repeat (3) cycle(4'd0, 1'b1);
        check_eq("reset.green",  32'(a_green),  32'h1);
        check_eq("reset.yellow", 32'(a_yellow), 32'h0);
        check_eq("reset.red",    32'(a_red),    32'h6);
        check_eq("reset.seg0",   32'(a_seg),    32'h40);

        repeat (50) begin
            cycle(4'd0, 1'b0);
            check_eq("idle.green", 32'(a_green), 32'h1);
        end

        // One-cycle car[2] pulse: two yellow, one all-red, then green on 2.
        cycle(4'b0100, 1'b0);
        cycle(4'd0, 1'b0);
        check_eq("pulse.yellow1", 32'(a_yellow), 32'h1);
        cycle(4'd0, 1'b0);
        check_eq("pulse.yellow2", 32'(a_yellow), 32'h1);
        cycle(4'd0, 1'b0);
        check_eq("pulse.allred", 32'(a_red), 32'h7);
        cycle(4'd0, 1'b0);
        check_eq("pulse.green2", 32'(a_green), 32'h4);
        check_eq("pulse.seg2",   32'(a_seg),   32'h24);

        // All sensors held from reset: served in order 0,1,2,0.
        repeat (2) cycle(4'd0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            cycle(4'b1111, 1'b0);
            if (a_green != 3'd0 && (order_q.size() == 0 || order_q[$] != a_green))
                order_q.push_back(a_green);
        end
        check_eq("rr.first",  32'(order_q.size() > 0 ? order_q[0] : 3'd0), 32'h1);
        check_eq("rr.second", 32'(order_q.size() > 1 ? order_q[1] : 3'd0), 32'h2);
        check_eq("rr.third",  32'(order_q.size() > 2 ? order_q[2] : 3'd0), 32'h4);
        check_eq("rr.fourth", 32'(order_q.size() > 3 ? order_q[3] : 3'd0), 32'h1);

        // Reset during the second yellow cycle: no tail, pending request dropped.
        cycle(4'd0, 1'b1);
        repeat (5) cycle(4'd0, 1'b0);
        cycle(4'b0010, 1'b0);
        cycle(4'd0, 1'b0);
        check_eq("midy.yellow", 32'(a_yellow), 32'h1);
        cycle(4'd0, 1'b1);
        check_eq("midy.green",  32'(a_green),  32'h1);
        check_eq("midy.noyel",  32'(a_yellow), 32'h0);
        repeat (10) cycle(4'd0, 1'b0);
        check_eq("midy.req_cleared", 32'(a_green), 32'h1);

        for (int i = 0; i < 2000; i++) begin
            c = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if (i % 400 > 350) c = 4'($urandom);
            r = ($urandom_range(0, 199) == 0) ||
                ((e_yellow[0] != 4'd0) && ($urandom_range(0, 15) == 0));
            cycle(c, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
